// File: rtl/jam_solver_param.sv
// Exhaustive N-worker x N-job assignment solver: walks all permutations in lexicographic order.
// Optional macro JAM_BEST_PERM_EN adds the BestPerm output (lexicographically first optimum).
module jam_solver_param #(
    parameter  int N    = 8,
    parameter  int CW   = 7,
    parameter  int MC_W = 16,
    localparam int IW   = (N <= 2) ? 1 : $clog2(N),
    localparam int TW   = CW + IW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            Start,
    input  logic [CW-1:0]   Cost,
    output logic [IW-1:0]   W,
    output logic [IW-1:0]   J,
    output logic            Busy,
    output logic            Valid,
    output logic [TW-1:0]   MinCost,
    output logic [MC_W-1:0] MatchCount
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*IW-1:0] BestPerm
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nx;
    logic [TW-1:0]   acc;
    logic [IW-1:0]   perm    [N];
    logic [IW-1:0]   perm_nx [N];
    logic [IW-1:0]   swp     [N];
    logic            perm_last;
    logic            start_acc;
    logic            last_fetch;
    int              pivot;
    int              succ;

    function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] v);
        return (&v) ? v : v + MC_W'(1);
    endfunction

    // Busy is low only in IDLE or in DONE once the result is published
    assign start_acc  = Start && !Busy;
    assign last_fetch = (idx == IW'(N - 1));
    assign idx_nx     = idx + IW'(1);

    // Next lexicographic permutation: pivot, swap with rightmost larger, reverse suffix
    always_comb begin
        perm_last = 1'b1;
        pivot     = 0;
        succ      = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                pivot     = i;
                perm_last = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k > pivot && perm[k] > perm[pivot]) succ = k;
        end
        swp         = perm;
        swp[pivot]  = perm[succ];
        swp[succ]   = perm[pivot];
        perm_nx     = swp;
        for (int k = 0; k < N; k++) begin
            if (k > pivot) perm_nx[k] = swp[N + pivot - k];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_acc) state_nx = S_FETCH;
            S_FETCH:  if (last_fetch) state_nx = S_UPDATE;
            S_UPDATE: state_nx = perm_last ? S_DONE : S_FETCH;
            S_DONE:   if (start_acc) state_nx = S_FETCH;
            default:  state_nx = S_IDLE;
        endcase
    end

`ifdef JAM_BEST_PERM_EN
    logic [IW-1:0] best [N];
    for (genvar g = 0; g < N; g++) begin : g_best
        assign BestPerm[g*IW +: IW] = best[g];
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= '0;
            W          <= '0;
            J          <= '0;
            Busy       <= 1'b0;
            Valid      <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            acc        <= '0;
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
`ifdef JAM_BEST_PERM_EN
            for (int i = 0; i < N; i++) best[i] <= IW'(i);
`endif
        end else if (start_acc) begin
            idx        <= '0;
            W          <= '0;
            J          <= '0;
            Busy       <= 1'b1;
            Valid      <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            acc        <= '0;
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
`ifdef JAM_BEST_PERM_EN
            for (int i = 0; i < N; i++) best[i] <= IW'(i);
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    acc <= acc + TW'(Cost);
                    if (!last_fetch) begin
                        idx <= idx_nx;
                        W   <= idx_nx;
                        J   <= perm[idx_nx];
                    end
                end
                S_UPDATE: begin
                    if (acc < MinCost) begin
                        MinCost    <= acc;
                        MatchCount <= MC_W'(1);
`ifdef JAM_BEST_PERM_EN
                        best       <= perm;
`endif
                    end else if (acc == MinCost) begin
                        MatchCount <= sat_inc(MatchCount);
                    end
                    acc <= '0;
                    if (!perm_last) begin
                        perm <= perm_nx;
                        idx  <= '0;
                        W    <= '0;
                        J    <= perm_nx[0];
                    end
                end
                S_DONE: begin
                    Valid <= 1'b1;
                    Busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_solver_param.sv
// Scoreboard bench for jam_solver_param: three instances (N=4 MC_W=4, N=3, N=5) sharing clock and reset.
module tb_jam_solver_param;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    // instance A: N=4, MC_W=4
    logic       sa = 1'b0;
    logic [6:0] ca;
    logic [1:0] wa, ja;
    logic       ba, va;
    logic [8:0] mina;
    logic [3:0] cnta;
    // instance B: N=3
    logic        sb_start = 1'b0;
    logic [6:0]  cb;
    logic [1:0]  wb, jb;
    logic        bb, vb;
    logic [8:0]  minb;
    logic [15:0] cntb;
    // instance C: N=5
    logic        sc = 1'b0;
    logic [6:0]  cc;
    logic [2:0]  wc, jc;
    logic        bc, vc;
    logic [9:0]  minc;
    logic [15:0] cntc;

    int mat_a [8][8];
    int mat_b [8][8];
    int mat_c [8][8];

    assign ca = 7'(mat_a[wa][ja]);
    assign cb = 7'(mat_b[wb][jb]);
    assign cc = 7'(mat_c[wc][jc]);

`ifdef JAM_BEST_PERM_EN
    logic [7:0]  bpa;
    logic [5:0]  bpb;
    logic [14:0] bpc;
`endif

    jam_solver_param #(.N(4), .CW(7), .MC_W(4)) u_a (
        .CLK(CLK), .RST_N(RST_N), .Start(sa), .Cost(ca), .W(wa), .J(ja),
        .Busy(ba), .Valid(va), .MinCost(mina), .MatchCount(cnta)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bpa)
`endif
    );
    jam_solver_param #(.N(3), .CW(7), .MC_W(16)) u_b (
        .CLK(CLK), .RST_N(RST_N), .Start(sb_start), .Cost(cb), .W(wb), .J(jb),
        .Busy(bb), .Valid(vb), .MinCost(minb), .MatchCount(cntb)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bpb)
`endif
    );
    jam_solver_param #(.N(5), .CW(7), .MC_W(16)) u_c (
        .CLK(CLK), .RST_N(RST_N), .Start(sc), .Cost(cc), .W(wc), .J(jc),
        .Busy(bc), .Valid(vc), .MinCost(minc), .MatchCount(cntc)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bpc)
`endif
    );

    typedef struct packed {
        int mn;
        int cnt;
        int best;
        int lat;
    } exp_t;

    exp_t sbq [$];
    int   ncomp = 0;
    int   nfail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        ncomp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_valid(input int s);
        case (s)
            0: return int'(va);
            1: return int'(vb);
            default: return int'(vc);
        endcase
    endfunction
    function automatic int get_busy(input int s);
        case (s)
            0: return int'(ba);
            1: return int'(bb);
            default: return int'(bc);
        endcase
    endfunction
    function automatic int get_min(input int s);
        case (s)
            0: return int'(mina);
            1: return int'(minb);
            default: return int'(minc);
        endcase
    endfunction
    function automatic int get_cnt(input int s);
        case (s)
            0: return int'(cnta);
            1: return int'(cntb);
            default: return int'(cntc);
        endcase
    endfunction
    function automatic int get_w(input int s);
        case (s)
            0: return int'(wa);
            1: return int'(wb);
            default: return int'(wc);
        endcase
    endfunction
    function automatic int get_j(input int s);
        case (s)
            0: return int'(ja);
            1: return int'(jb);
            default: return int'(jc);
        endcase
    endfunction
`ifdef JAM_BEST_PERM_EN
    function automatic int get_best(input int s);
        case (s)
            0: return int'(bpa);
            1: return int'(bpb);
            default: return int'(bpc);
        endcase
    endfunction
`endif

    task automatic set_start(input int s, input logic v);
        case (s)
            0: sa = v;
            1: sb_start = v;
            default: sc = v;
        endcase
    endtask

    // Brute-force reference: every n-tuple in lexicographic order, keep the distinct ones
    task automatic model(input int n, input int s, input int mcw,
                         output int mn, output int cnt, output int best);
        int m [8][8];
        int p [8];
        int total, tot, used, t, iw, lim;
        bit ok;
        case (s)
            0: m = mat_a;
            1: m = mat_b;
            default: m = mat_c;
        endcase
        iw = (n <= 2) ? 1 : $clog2(n);
        total = 1;
        for (int i = 0; i < n; i++) total *= n;
        mn = 32'h7fffffff;
        cnt = 0;
        best = 0;
        for (int k = 0; k < total; k++) begin
            t = k;
            for (int i = n - 1; i >= 0; i--) begin
                p[i] = t % n;
                t = t / n;
            end
            used = 0;
            ok = 1'b1;
            tot = 0;
            for (int i = 0; i < n; i++) begin
                if (used[p[i]]) ok = 1'b0;
                used[p[i]] = 1'b1;
                tot += m[i][p[i]];
            end
            if (ok) begin
                if (tot < mn) begin
                    mn = tot;
                    cnt = 1;
                    best = 0;
                    for (int i = 0; i < n; i++) best |= p[i] << (i * iw);
                end else if (tot == mn) begin
                    cnt++;
                end
            end
        end
        lim = (1 << mcw) - 1;
        if (cnt > lim) cnt = lim;
    endtask

    task automatic run(input string tag, input int s, input int n, input int mcw,
                       input int busy_start_at);
        exp_t e, got;
        int   mn, cnt, best, lat, fct;
        bit   done;
        model(n, s, mcw, mn, cnt, best);
        fct = 1;
        for (int i = 2; i <= n; i++) fct *= i;
        e.mn   = mn;
        e.cnt  = cnt;
        e.best = best;
        e.lat  = fct * (n + 1) + 1;
        sbq.push_back(e);

        @(posedge CLK); #1;
        set_start(s, 1'b1);
        @(posedge CLK); #1;
        check({tag, "_busy_at_start"}, get_busy(s), 1);
        check({tag, "_valid_at_start"}, get_valid(s), 0);
        check({tag, "_w_at_start"}, get_w(s), 0);
        check({tag, "_j_at_start"}, get_j(s), 0);

        lat  = 0;
        done = 1'b0;
        while (!done && lat < e.lat + 20) begin
            set_start(s, (lat == busy_start_at) ? 1'b1 : 1'b0);
            @(posedge CLK); #1;
            lat++;
            done = (get_valid(s) == 1);
        end
        set_start(s, 1'b0);

        got = sbq.pop_front();
        check({tag, "_latency"}, lat, got.lat);
        check({tag, "_mincost"}, get_min(s), got.mn);
        check({tag, "_matchcount"}, get_cnt(s), got.cnt);
        check({tag, "_busy_done"}, get_busy(s), 0);
`ifdef JAM_BEST_PERM_EN
        check({tag, "_bestperm"}, get_best(s), got.best);
`endif
        repeat (3) @(posedge CLK);
        #1;
        check({tag, "_valid_held"}, get_valid(s), 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                mat_a[i][k] = 0;
                mat_b[i][k] = 0;
                mat_c[i][k] = 0;
            end

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", int'(ba), 0);
        check("rst_valid", int'(va), 0);
        check("rst_min_a", int'(mina), 511);
        check("rst_min_c", int'(minc), 1023);
        check("rst_cnt", int'(cnta), 0);
        check("rst_wj", int'({wc, jc}), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // N=3 uniform cost 1
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_b[i][k] = 1;
        run("b_uniform", 1, 3, 16, -1);

        // N=4 diagonal zero, off-diagonal 10
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_a[i][k] = (i == k) ? 0 : 10;
        run("a_diag", 0, 4, 4, -1);

        // N=4 uniform 5, 4-bit counter saturates at 15
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_a[i][k] = 5;
        run("a_sat", 0, 4, 4, -1);

        // Random costs, Start re-pulsed while busy, then restart from DONE
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_a[i][k] = int'($urandom_range(0, 127));
        run("a_busy_start", 0, 4, 4, 10);
        run("a_restart", 0, 4, 4, -1);

        // N=5: reset mid-FETCH aborts immediately
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_c[i][k] = int'($urandom_range(0, 127));
        @(posedge CLK); #1;
        sc = 1'b1;
        @(posedge CLK); #1;
        sc = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("c_rst_busy", int'(bc), 0);
        check("c_rst_valid", int'(vc), 0);
        check("c_rst_min", int'(minc), 1023);
        check("c_rst_cnt", int'(cntc), 0);
        check("c_rst_w", int'(wc), 0);
        check("c_rst_j", int'(jc), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run("c_rand", 2, 5, 16, -1);

        // N=5, cost equals job index: every assignment totals 10
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mat_c[i][k] = k;
        run("c_costj", 2, 5, 16, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/jam_solver_param.md
Name: jam_solver_param

Overview:
- Exhaustive job-assignment solver, generalised to N workers × N jobs.
- Enumerates every permutation of jobs over workers in lexicographic order and fetches each cost from an external combinational cost table through the W/J/Cost interface.
- Reports the minimum total cost and how many assignments reach it.
- Adds a start/busy handshake, a saturating match counter and parametrised widths; sits between the test harness/controller and the cost ROM.

Parameters:
- N, 8, number of workers and jobs; legal range 2..8.
- CW, 7, width of one Cost entry.
- MC_W, 16, width of MatchCount; the counter saturates at all-ones.
- IW, $clog2(N) (min 1), derived width of W/J.
- TW, CW+IW, derived width of total/MinCost.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle request to begin a full search.
- Cost  in  CW  cost of worker W doing job J; combinational response to the current W/J.
- W  out  IW  worker index being fetched (registered).
- J  out  IW  job index assigned to worker W in the current permutation (registered).
- Busy  out  1  high from start acceptance until Valid rises.
- Valid  out  1  result ready; held until the next accepted Start or reset.
- MinCost  out  TW  minimum total cost found.
- MatchCount  out  MC_W  number of permutations with total == MinCost, saturating.

Behaviour:
- Reset values (async, RST_N low): state IDLE; W=0; J=0; Busy=0; Valid=0; MinCost=all-ones; MatchCount=0; perm[i]=i; accumulator=0.
- States and transitions:
  - IDLE: wait for Start. Start=1 accepted → FETCH.
  - FETCH: N cycles, idx 0..N-1. Each rising edge adds Cost to the accumulator; W=idx and J=perm[idx] are registered one cycle ahead so Cost is valid at the sampling edge. After idx=N-1 → UPDATE.
  - UPDATE: 1 cycle. Then → FETCH (next permutation) or → DONE.
  - DONE: Valid=1, Busy=0; W/J hold their last values. Start → FETCH.
- Start acceptance (from IDLE or DONE):
  - Re-initialises perm to identity, MinCost=all-ones, MatchCount=0, accumulator=0, Valid=0.
  - Sets Busy=1 and presents W=0, J=0.
- UPDATE cycle actions:
  - total < MinCost: MinCost ← total, MatchCount ← 1.
  - total == MinCost: MatchCount ← MatchCount+1, saturating at 2^MC_W−1.
  - Accumulator cleared.
  - If perm is strictly descending (the last permutation) → DONE. Otherwise perm ← next lexicographic permutation:
    - pivot = rightmost i with perm[i] < perm[i+1];
    - swap perm[pivot] with the rightmost element greater than it;
    - reverse the suffix after pivot.
  - The next-permutation logic is combinational over N, one update per UPDATE cycle.
  - W/J for the new permutation's idx 0 are presented on the same edge.
- Latency: Valid rises exactly N!·(N+1)+1 rising edges after the edge that accepted Start (N=8: 362881).
- Start while Busy=1 is ignored.
- The accumulator is TW bits wide and cannot overflow; N·(2^CW−1) < 2^TW.
- Reset asserted mid-search aborts immediately to reset values. No result is retained.
- MinCost remains all-ones only until the first UPDATE; the first permutation always sets MatchCount=1.

Optional Feature:
- Macro JAM_BEST_PERM_EN.
- When defined:
  - Adds output BestPerm, width N·IW. Field i (bits i·IW+IW−1 : i·IW) is the job of worker i.
  - Captures perm on every strict-less update, so it holds the lexicographically first optimal assignment.
  - Reset and Start acceptance set it to identity.
- When undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- N=3, Cost=1 for all W/J, Start pulse → Valid rises 25 edges after Start; MinCost=3; MatchCount=6.
- N=4, Cost=0 if W==J else 10 → MinCost=0; MatchCount=1; BestPerm (if enabled)=identity {3,2,1,0}.
- N=8, Cost=J → every total=28; MinCost=28; MatchCount=40320; Valid at edge 362881.
- N=4, MC_W=4, uniform Cost=5 → MinCost=20; MatchCount saturates at 15 (not 24 or wrapped to 8).
- N=4, Start pulsed again while Busy → ignored, Valid timing unchanged (121 edges). Start pulsed in DONE → Valid drops next cycle and the search restarts with identical results.
- N=5, RST_N pulled low mid-FETCH → Busy=0, Valid=0, MinCost=all-ones, MatchCount=0, W=J=0 immediately. A new Start completes normally.
